prescaled_mod_counter: RTL and testbench

PRESCALED_MOD_COUNTER -- requirements
Module: prescaled_mod_counter

---
 rtl/prescaled_mod_counter_pkg.sv | 9 +
 rtl/prescaled_mod_counter_if.sv | 28 ++
 rtl/prescaled_mod_counter_prescaler.sv | 33 +++
 rtl/prescaled_mod_counter.sv | 90 +++++++++
 tb/tb_prescaled_mod_counter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/prescaled_mod_counter_pkg.sv
// Shared encodings for the prescaled modulo counter: direction and overflow-mode values.
package prescaled_mod_counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

endpackage

// File: rtl/prescaled_mod_counter_if.sv
// Control/status bundle of the prescaled modulo counter; the master drives controls, the slave returns count/tick/tc.
interface prescaled_mod_counter_if #(
    parameter int WIDTH = 8,
    parameter int PW    = 30
);

    logic [PW-1:0]    period;
    logic [WIDTH-1:0] limit;
    logic             enable;
    logic             up_down;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             tc;

    modport master (
        output period, limit, enable, up_down, mode, load, load_value,
        input  count, tick, tc
    );

    modport slave (
        input  period, limit, enable, up_down, mode, load, load_value,
        output count, tick, tc
    );

endinterface

// File: rtl/prescaled_mod_counter_prescaler.sv
// Divides enabled clock cycles by 'period' and emits a one-cycle strobe on the last cycle of each period.
module tick_prescaler #(
    parameter int PW = 30
) (
    input  logic          CLK_50M,
    input  logic          RESET,
    input  logic [PW-1:0] period,
    input  logic          enable,
    input  logic          clear,
    output logic          strobe
);

    logic [PW-1:0] r_preCnt;
    logic          w_atEnd;

    // '>=' rather than '==' so a runtime shrink of period cannot strand the counter past its end.
    always_comb begin
        w_atEnd = (period <= PW'(1)) || (r_preCnt >= (period - PW'(1)));
    end

    assign strobe = enable && w_atEnd;

    always_ff @(posedge CLK_50M) begin
        if (RESET || clear) begin
            r_preCnt <= '0;
        end else if (strobe) begin
            r_preCnt <= '0;
        end else if (enable) begin
            r_preCnt <= r_preCnt + PW'(1);
        end
    end

endmodule

// File: rtl/prescaled_mod_counter.sv
// Up/down modulo counter advanced by a prescaled strobe, with wrap or saturate behaviour and synchronous load.
module prescaled_mod_counter
    import prescaled_mod_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PW    = 30
) (
    input  logic                  CLK_50M,
    input  logic                  RESET,
    prescaled_mod_counter_if.slave bus
);

    logic [WIDTH-1:0] r_count;
    logic             r_tick;
    logic             r_tc;
    logic             w_strobe;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_nextCount;
    logic             w_nextTick;
    logic             w_nextTc;

    tick_prescaler #(.PW(PW)) u_prescaler (
        .CLK_50M (CLK_50M),
        .RESET   (RESET),
        .period  (bus.period),
        .enable  (bus.enable),
        .clear   (bus.load),
        .strobe  (w_strobe)
    );

    // limit==0 selects the full 2^WIDTH range, so TOP becomes all ones.
    always_comb begin
        w_top = (bus.limit == '0) ? '1 : (bus.limit - WIDTH'(1));
    end

    always_comb begin
        w_nextCount = r_count;
        w_nextTick  = 1'b0;
        w_nextTc    = 1'b0;
        if (bus.load) begin
            w_nextCount = (bus.load_value > w_top) ? w_top : bus.load_value;
        end else if (w_strobe) begin
            w_nextTick = 1'b1;
            unique case (bus.up_down)
                DIR_UP: begin
                    if (r_count < w_top) begin
                        w_nextCount = r_count + WIDTH'(1);
                    end else if (bus.mode == MODE_WRAP) begin
                        w_nextCount = '0;
                        w_nextTc    = 1'b1;
                    end else begin
                        w_nextCount = w_top;
                        w_nextTc    = (r_count != w_top);
                    end
                end
                DIR_DOWN: begin
                    // Out-of-range values left behind by a shrinking limit snap back to TOP silently.
                    if (r_count > w_top) begin
                        w_nextCount = w_top;
                    end else if (r_count == '0) begin
                        if (bus.mode == MODE_WRAP) begin
                            w_nextCount = w_top;
                            w_nextTc    = 1'b1;
                        end
                    end else begin
                        w_nextCount = r_count - WIDTH'(1);
                        w_nextTc    = (bus.mode == MODE_SAT) && (r_count == WIDTH'(1));
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            r_count <= '0;
            r_tick  <= 1'b0;
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_nextCount;
            r_tick  <= w_nextTick;
            r_tc    <= w_nextTc;
        end
    end

    assign bus.count = r_count;
    assign bus.tick  = r_tick;
    assign bus.tc    = r_tc;

endmodule

// File: tb/tb_prescaled_mod_counter.sv
// Self-checking bench: an integer-arithmetic reference model checked every cycle plus directed literal checks.
module tb_prescaled_mod_counter;
    import prescaled_mod_counter_pkg::*;

    localparam int WIDTH = 8;
    localparam int PW    = 30;

    logic CLK_50M = 1'b0;
    logic RESET;
    int   nChecks = 0;
    int   nFails  = 0;
    bit   checkEn = 1'b0;

    longint mPre;
    int     mCount;
    int     mTick;
    int     mTc;

    prescaled_mod_counter_if #(.WIDTH(WIDTH), .PW(PW)) bus ();

    prescaled_mod_counter #(.WIDTH(WIDTH), .PW(PW)) dut (
        .CLK_50M (CLK_50M),
        .RESET   (RESET),
        .bus     (bus)
    );

    always #10 CLK_50M = ~CLK_50M;

    // Reference model: TOP from limit, a count of enabled cycles since the last strobe, and the counting rules in plain integers.
    always @(posedge CLK_50M) begin
        int     top;
        longint per;
        bit     strobe;
        if (RESET) begin
            mCount = 0; mPre = 0; mTick = 0; mTc = 0;
        end else begin
            top    = (bus.limit == 0) ? (1 << WIDTH) - 1 : int'(bus.limit) - 1;
            per    = longint'(bus.period);
            strobe = bus.enable && (per <= 1 || mPre + 1 >= per);
            mTick  = 0;
            mTc    = 0;
            if (bus.load) begin
                mCount = (int'(bus.load_value) < top) ? int'(bus.load_value) : top;
                mPre   = 0;
            end else begin
                if (bus.enable) mPre = strobe ? 0 : mPre + 1;
                if (strobe) begin
                    mTick = 1;
                    if (bus.up_down == DIR_UP) begin
                        if (mCount < top) mCount = mCount + 1;
                        else begin
                            mTc    = (bus.mode == MODE_WRAP || mCount != top) ? 1 : 0;
                            mCount = (bus.mode == MODE_WRAP) ? 0 : top;
                        end
                    end else begin
                        if (mCount > top) mCount = top;
                        else if (mCount == 0) begin
                            if (bus.mode == MODE_WRAP) begin mCount = top; mTc = 1; end
                        end else begin
                            mCount = mCount - 1;
                            mTc    = (bus.mode == MODE_SAT && mCount == 0) ? 1 : 0;
                        end
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle after reset the DUT must agree with the model.
    always @(negedge CLK_50M) begin
        if (checkEn) begin
            checkOutput("model.count", 32'(bus.count), 32'(mCount));
            checkOutput("model.tick",  32'(bus.tick),  32'(mTick));
            checkOutput("model.tc",    32'(bus.tc),    32'(mTc));
        end
    end

    task automatic applyStimulus(input int per, input int lim, input bit en, input bit dir,
                                 input bit md, input bit ld, input int lv);
        bus.period     = PW'(per);
        bus.limit      = WIDTH'(lim);
        bus.enable     = en;
        bus.up_down    = dir;
        bus.mode       = md;
        bus.load       = ld;
        bus.load_value = WIDTH'(lv);
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(negedge CLK_50M);
    endtask

    task automatic checkTriple(input string name, input int c, input int t, input int x);
        checkOutput({name, ".count"}, 32'(bus.count), 32'(c));
        checkOutput({name, ".tick"},  32'(bus.tick),  32'(t));
        checkOutput({name, ".tc"},    32'(bus.tc),    32'(x));
    endtask

    initial begin
        RESET = 1'b1;
        applyStimulus(5, 10, 1'b0, DIR_UP, MODE_WRAP, 1'b1, 77);
        runCycles(1);
        checkEn = 1'b1;
        checkTriple("reset", 0, 0, 0);

        // Period 5, limit 10, up, wrap: tick every 5 cycles, tc on 9->0.
        RESET = 1'b0;
        applyStimulus(5, 10, 1'b1, DIR_UP, MODE_WRAP, 1'b0, 0);
        runCycles(4);
        checkTriple("p5.pre", 0, 0, 0);
        runCycles(1);
        checkTriple("p5.first", 1, 1, 0);
        runCycles(45);
        checkTriple("p5.wrap", 0, 1, 1);
        runCycles(1);
        checkTriple("p5.after", 0, 0, 0);

        // Down, saturate from 3.
        applyStimulus(5, 10, 1'b1, DIR_DOWN, MODE_SAT, 1'b1, 3);
        runCycles(1);
        checkTriple("sat.load", 3, 0, 0);
        bus.load = 1'b0;
        runCycles(15);
        checkTriple("sat.zero", 0, 1, 1);
        runCycles(5);
        checkTriple("sat.hold", 0, 1, 0);

        // Full range, period 1, across 255.
        applyStimulus(1, 0, 1'b1, DIR_UP, MODE_WRAP, 1'b1, 254);
        runCycles(1);
        checkTriple("full.load", 254, 0, 0);
        bus.load = 1'b0;
        runCycles(1);
        checkTriple("full.255", 255, 1, 0);
        runCycles(1);
        checkTriple("full.wrap", 0, 1, 1);
        runCycles(1);
        checkTriple("full.one", 1, 1, 0);

        // Limit shrinks under a count of 7.
        applyStimulus(1, 10, 1'b1, DIR_UP, MODE_WRAP, 1'b1, 7);
        runCycles(1);
        bus.load = 1'b0; bus.limit = 8'd5;
        runCycles(1);
        checkTriple("shrink.wrap", 0, 1, 1);
        applyStimulus(1, 10, 1'b1, DIR_UP, MODE_SAT, 1'b1, 7);
        runCycles(1);
        bus.load = 1'b0; bus.limit = 8'd5;
        runCycles(1);
        checkTriple("shrink.sat", 4, 1, 1);
        runCycles(1);
        checkTriple("shrink.sat2", 4, 1, 0);

        // Down wrap corners and count above TOP.
        applyStimulus(1, 10, 1'b1, DIR_DOWN, MODE_WRAP, 1'b1, 0);
        runCycles(1);
        bus.load = 1'b0;
        runCycles(1);
        checkTriple("down.wrap0", 9, 1, 1);
        applyStimulus(1, 10, 1'b1, DIR_DOWN, MODE_WRAP, 1'b1, 1);
        runCycles(1);
        bus.load = 1'b0;
        runCycles(1);
        checkTriple("down.wrap1", 0, 1, 0);
        applyStimulus(1, 10, 1'b1, DIR_DOWN, MODE_WRAP, 1'b1, 8);
        runCycles(1);
        bus.load = 1'b0; bus.limit = 8'd5;
        runCycles(1);
        checkTriple("down.above", 4, 1, 0);

        // Load in a strobe cycle wins and clamps to TOP.
        applyStimulus(4, 10, 1'b1, DIR_UP, MODE_WRAP, 1'b1, 0);
        runCycles(1);
        bus.load = 1'b0;
        runCycles(3);
        bus.load = 1'b1; bus.load_value = 8'd12;
        runCycles(1);
        checkTriple("ldstrobe", 9, 0, 0);
        bus.load = 1'b0;
        runCycles(3);
        checkTriple("ldstrobe.wait", 9, 0, 0);
        runCycles(1);
        checkTriple("ldstrobe.next", 0, 1, 1);

        // Reset mid-period overrides a concurrent load.
        applyStimulus(5, 10, 1'b1, DIR_UP, MODE_WRAP, 1'b1, 6);
        runCycles(1);
        bus.load = 1'b0;
        runCycles(2);
        RESET = 1'b1; bus.load = 1'b1; bus.load_value = 8'd3;
        runCycles(1);
        checkTriple("midreset", 0, 0, 0);
        RESET = 1'b0; bus.load = 1'b0;
        runCycles(4);
        checkTriple("midreset.wait", 0, 0, 0);
        runCycles(1);
        checkTriple("midreset.first", 1, 1, 0);

        // Enable low freezes everything.
        bus.enable = 1'b0;
        runCycles(10);
        checkTriple("disabled", 1, 0, 0);
        bus.enable = 1'b1;
        runCycles(5);
        checkTriple("reenabled", 2, 1, 0);

        runCycles(2);
        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
